fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end for the 16-bit RISC core. It is the initiator on the instruction-memory read port: it drives a byte-addressed PC and captures the returned 16-bit word. It presents each instruction and its PC to decode through a valid/ready handshake. It also handles branch redirects, halt/resume, and misaligned redirect targets.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC loaded on reset; must be even.
- HALT_WORD, 16'hFFFF, instruction encoding that halts fetch.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  16  byte address to instruction memory; equals the pc register (combinational).
- imem_data  in  16  instruction word; combinational read, valid in the same cycle as imem_addr.
- dec_instr  out  16  registered instruction to decode.
- dec_pc  out  16  registered address of dec_instr.
- dec_valid  out  1  dec_instr/dec_pc hold a live instruction.
- dec_ready  in  1  decode accepts the instruction this cycle.
- redirect  in  1  branch/jump taken; single-cycle pulse.
- redirect_pc  in  16  target byte address.
- resume  in  1  leave HALT; single-cycle pulse.
- halted  out  1  high while state is HALT.
- misalign  out  1  sticky flag: a redirect target had bit 0 set.

## Operation
- States are IDLE, RUN and HALT. Reset enters IDLE.
- IDLE → RUN unconditionally after one cycle. A redirect in IDLE also goes to RUN.
- Fetch fires when state is RUN, redirect is low, and (dec_valid is low or dec_ready is high). On fire:
  - dec_instr ← imem_data
  - dec_pc ← pc
  - dec_valid ← 1
  - pc ← pc + 2, modulo 2^16, so 16'hFFFE wraps to 16'h0000.
- Stall: when dec_valid && !dec_ready && !redirect, pc, dec_* and state all hold.
- Drain: when dec_valid && dec_ready and no fire (HALT or IDLE), dec_valid ← 0.
- Redirect has the highest priority, in any state:
  - dec_valid ← 0, which flushes any held instruction whether accepted or not.
  - pc ← {redirect_pc[15:1], 1'b0}.
  - state ← RUN.
  - If redirect_pc[0] is set, misalign ← 1. It stays set until reset.
- Halt: a fired instruction equal to HALT_WORD is still delivered to decode, and pc still advances. State then becomes HALT, and no further fetches occur.
- resume in HALT → RUN with pc unchanged. resume in IDLE or RUN is ignored. redirect and resume together means redirect wins, with the same end state RUN.
- halted = (state == HALT).

## Timing
- Reset values:
  - pc = RESET_PC
  - dec_instr = 16'h0000, dec_pc = 16'h0000
  - dec_valid = 0, halted = 0, misalign = 0
  - state = IDLE
- Startup: cycle 0 after rst deasserts is IDLE. Cycle 1 fetches RESET_PC. dec_valid is first high in cycle 2.
- Throughput is one instruction per cycle while dec_ready stays high.
- Fetch-to-decode latency is 1 cycle (one output register; no internal FIFO).
- Redirect in cycle n:
  - dec_valid is low in n+1.
  - The target is fetched in n+1 and is valid in n+2.
  - This gives exactly one bubble.
- HALT fetched in cycle n: halted is high from n+1, and dec_valid remains high until accepted.
- resume in cycle n: fetch in n+1, valid in n+2.
- rst assertion mid-operation immediately (asynchronously) forces all reset values. A held, unaccepted instruction is lost.

## Structure
- Shared package cpu_pkg holds:
  - the fetch_state_t enum (IDLE, RUN, HALT)
  - INSTR_W = 16, ADDR_W = 16
  - PC_STEP = 16'd2
  - the default HALT_WORD constant
- No sub-modules: a single module containing the pc register, the output register and the state machine. instr_mem is instantiated beside it at core top level, not inside.

## Test plan
- Reset release with memory words 0x1111, 0x2222, 0x3333 at bytes 0, 2, 4 and dec_ready = 1 → dec_valid rises in cycle 2, followed by (0x0000, 0x1111), (0x0002, 0x2222), (0x0004, 0x3333) on consecutive cycles.
- Hold dec_ready = 0 for 3 cycles while showing 0x2222 → dec_instr, dec_pc and imem_addr are stable. After release, 0x3333 follows in the next cycle with no duplicate or skip.
- redirect with redirect_pc = 0x0040 while an instruction is stalled → the next cycle has dec_valid = 0 and imem_addr = 0x0040. The cycle after shows dec_pc = 0x0040.
- redirect_pc = 0x0041 → fetch from 0x0040 and misalign = 1. misalign stays 1 across later redirects and clears only on rst.
- HALT_WORD at 0x0006 → it is delivered with dec_pc = 0x0006, then halted = 1 with no new valid. A resume pulse gives the next dec_pc = 0x0008.
- pc at 0xFFFE with dec_ready = 1 → the next fetch address is 0x0000. rst asserted mid-stream → all outputs reset asynchronously, and the sequence restarts from RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the 16-bit RISC core
package cpu_pkg;
  localparam int INSTR_W = 16;
  localparam int ADDR_W = 16;
  localparam logic [ADDR_W-1:0] PC_STEP = 16'd2;
  localparam logic [INSTR_W-1:0] DEFAULT_HALT_WORD = 16'hFFFF;
  typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory read port and decode handshake
interface fetch_unit_if;
  import cpu_pkg::*;
  logic [ADDR_W-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] dec_instr;
  logic [ADDR_W-1:0] dec_pc;
  logic dec_valid;
  logic dec_ready;
  modport master (output imem_addr, dec_instr, dec_pc, dec_valid, input imem_data, dec_ready);
  modport slave (input imem_addr, dec_instr, dec_pc, dec_valid, output imem_data, dec_ready);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: pc register, decode output register and IDLE/RUN/HALT control
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter logic [INSTR_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic clk,
  input  logic rst,
  fetch_unit_if.master bus,
  input  logic redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic resume,
  output logic halted,
  output logic misalign
);
  fetch_state_t state;
  logic [ADDR_W-1:0] pc;
  logic fire;
  assign bus.imem_addr = pc;
  assign halted = state == HALT;
  assign fire = state == RUN && !redirect && (!bus.dec_valid || bus.dec_ready);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      bus.dec_instr <= '0;
      bus.dec_pc <= '0;
      bus.dec_valid <= 1'b0;
      misalign <= 1'b0;
    end else if (redirect) begin
      state <= RUN;
      pc <= {redirect_pc[ADDR_W-1:1], 1'b0};
      bus.dec_valid <= 1'b0;
      misalign <= misalign | redirect_pc[0];
    end else if (fire) begin
      bus.dec_instr <= bus.imem_data;
      bus.dec_pc <= pc;
      bus.dec_valid <= 1'b1;
      pc <= pc + PC_STEP;
      state <= bus.imem_data == HALT_WORD ? HALT : RUN;
    end else begin
      if (bus.dec_valid && bus.dec_ready) bus.dec_valid <= 1'b0;
      if (state == IDLE || (state == HALT && resume)) state <= RUN;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboarded, table-driven check of fetch_unit
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic resume = 1'b0;
  logic halted, misalign;
  logic [15:0] memw [0:255];
  int errors = 0;
  int checks = 0;
  typedef struct {logic [15:0] pc; logic [15:0] instr;} exp_t;
  typedef struct {logic [15:0] target; logic [15:0] addr; logic mis; logic rdy;} vec_t;
  exp_t q[$];
  exp_t e;
  vec_t vt[4];

  fetch_unit_if bus();
  fetch_unit dut (.clk(clk), .rst(rst), .bus(bus), .redirect(redirect), .redirect_pc(redirect_pc),
                  .resume(resume), .halted(halted), .misalign(misalign));

  always #5 clk = ~clk;
  assign bus.imem_data = memw[bus.imem_addr[8:1]];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] pc);
    q.push_back('{pc: pc, instr: memw[pc[8:1]]});
  endtask

  always @(negedge clk)
    if (!rst && bus.dec_valid && bus.dec_ready && !redirect) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL accept: unexpected pc %h instr %h, expected none", bus.dec_pc, bus.dec_instr);
      end else begin
        e = q.pop_front();
        chk("accept_pc", bus.dec_pc, e.pc);
        chk("accept_instr", bus.dec_instr, e.instr);
      end
    end

  initial begin
    for (int i = 0; i < 256; i++) memw[i] = 16'h8000 | 16'(i);
    memw[0] = 16'h1111;
    memw[1] = 16'h2222;
    memw[2] = 16'h3333;
    memw[3] = 16'hFFFF;
    vt[0] = '{target: 16'h0040, addr: 16'h0040, mis: 1'b0, rdy: 1'b0};
    vt[1] = '{target: 16'h0041, addr: 16'h0040, mis: 1'b1, rdy: 1'b1};
    vt[2] = '{target: 16'h0010, addr: 16'h0010, mis: 1'b1, rdy: 1'b0};
    vt[3] = '{target: 16'hFFFE, addr: 16'hFFFE, mis: 1'b1, rdy: 1'b1};
    bus.dec_ready = 1'b1;
    #2;
    chk("rst_valid", 16'(bus.dec_valid), 16'd0);
    chk("rst_instr", bus.dec_instr, 16'h0000);
    chk("rst_pc", bus.dec_pc, 16'h0000);
    chk("rst_addr", bus.imem_addr, 16'h0000);
    chk("rst_halted", 16'(halted), 16'd0);
    chk("rst_misalign", 16'(misalign), 16'd0);
    step();
    rst = 1'b0;
    push(16'h0000); push(16'h0002); push(16'h0004); push(16'h0006); push(16'h0008);
    step();
    chk("c1_valid", 16'(bus.dec_valid), 16'd0);
    chk("c1_addr", bus.imem_addr, 16'h0000);
    step();
    chk("c2_valid", 16'(bus.dec_valid), 16'd1);
    chk("c2_pc", bus.dec_pc, 16'h0000);
    chk("c2_instr", bus.dec_instr, 16'h1111);
    step();
    chk("c3_pc", bus.dec_pc, 16'h0002);
    bus.dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", bus.dec_pc, 16'h0002);
      chk("stall_instr", bus.dec_instr, 16'h2222);
      chk("stall_addr", bus.imem_addr, 16'h0004);
    end
    bus.dec_ready = 1'b1;
    step();
    chk("post_stall_pc", bus.dec_pc, 16'h0004);
    chk("post_stall_instr", bus.dec_instr, 16'h3333);
    step();
    chk("halt_pc", bus.dec_pc, 16'h0006);
    chk("halt_instr", bus.dec_instr, 16'hFFFF);
    chk("halt_halted", 16'(halted), 16'd1);
    bus.dec_ready = 1'b0;
    repeat (2) begin
      step();
      chk("halt_hold_valid", 16'(bus.dec_valid), 16'd1);
      chk("halt_hold_addr", bus.imem_addr, 16'h0008);
    end
    bus.dec_ready = 1'b1;
    step();
    chk("halt_drain_valid", 16'(bus.dec_valid), 16'd0);
    step();
    chk("halt_idle_valid", 16'(bus.dec_valid), 16'd0);
    chk("halt_idle_halted", 16'(halted), 16'd1);
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk("resume_halted", 16'(halted), 16'd0);
    chk("resume_valid", 16'(bus.dec_valid), 16'd0);
    chk("resume_addr", bus.imem_addr, 16'h0008);
    step();
    chk("resume_pc", bus.dec_pc, 16'h0008);
    chk("resume_valid2", 16'(bus.dec_valid), 16'd1);
    step();
    bus.dec_ready = 1'b0;
    step();
    chk("held_pc", bus.dec_pc, 16'h000A);
    chk("sb_phase1", 16'(q.size()), 16'd0);
    for (int i = 0; i < 4; i++) begin
      redirect = 1'b1;
      redirect_pc = vt[i].target;
      bus.dec_ready = vt[i].rdy;
      step();
      redirect = 1'b0;
      chk("redir_bubble", 16'(bus.dec_valid), 16'd0);
      chk("redir_addr", bus.imem_addr, vt[i].addr);
      chk("redir_misalign", 16'(misalign), 16'(vt[i].mis));
      bus.dec_ready = 1'b1;
      push(vt[i].addr);
      step();
      chk("redir_pc", bus.dec_pc, vt[i].addr);
      chk("redir_instr", bus.dec_instr, memw[vt[i].addr[8:1]]);
      chk("redir_next_addr", bus.imem_addr, vt[i].addr + 16'd2);
      step();
      bus.dec_ready = 1'b0;
    end
    chk("sb_phase2", 16'(q.size()), 16'd0);
    step();
    rst = 1'b1;
    #1;
    chk("arst_valid", 16'(bus.dec_valid), 16'd0);
    chk("arst_pc", bus.dec_pc, 16'h0000);
    chk("arst_instr", bus.dec_instr, 16'h0000);
    chk("arst_addr", bus.imem_addr, 16'h0000);
    chk("arst_misalign", 16'(misalign), 16'd0);
    chk("arst_halted", 16'(halted), 16'd0);
    q.delete();
    step();
    rst = 1'b0;
    push(16'h0000); push(16'h0002);
    bus.dec_ready = 1'b1;
    step();
    chk("restart_c1_valid", 16'(bus.dec_valid), 16'd0);
    step();
    chk("restart_pc0", bus.dec_pc, 16'h0000);
    step();
    chk("restart_pc2", bus.dec_pc, 16'h0002);
    step();
    bus.dec_ready = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) step();
    chk("sb_final", 16'(q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
